// File: rtl/rs_hs_pipeline_tail.sv
// Receive-side tail of the relay-station handshake pipeline: almost-full FIFO with
// registered upstream ready, show-ahead output, occupancy count and sticky overflow.
module rs_hs_pipeline_tail #(
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 24,
   parameter int GRACE_PERIOD    = 5,
   parameter int REAL_DEPTH      = GRACE_PERIOD + DEPTH + 4,
   parameter int REAL_ADDR_WIDTH = $clog2(REAL_DEPTH),
   parameter int CNT_WIDTH       = $clog2(REAL_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_valid,
   input  logic [DATA_WIDTH-1:0] if_data,
   output logic                  if_ready,
   output logic                  of_valid,
   output logic [DATA_WIDTH-1:0] of_data,
   input  logic                  of_ready,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow
);

   localparam logic [CNT_WIDTH-1:0]       FULL_CNT = CNT_WIDTH'(REAL_DEPTH);
   localparam logic [CNT_WIDTH-1:0]       THR_CNT  = CNT_WIDTH'(REAL_DEPTH - GRACE_PERIOD);
   localparam logic [REAL_ADDR_WIDTH-1:0] LAST_PTR = REAL_ADDR_WIDTH'(REAL_DEPTH - 1);

   logic [DATA_WIDTH-1:0]      mem_q [REAL_DEPTH];
   logic [REAL_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [REAL_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]       count_q, count_d;
   logic                       if_ready_q, if_ready_d;
   logic                       overflow_q, overflow_d;
   logic                       push, pop;

   // Upstream valid is deliberately not qualified by ready: grace-period words must land.
   always_comb begin
      push       = if_valid && (count_q != FULL_CNT);
      pop        = (count_q != '0) && of_ready;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      if (if_valid && (count_q == FULL_CNT)) begin
         overflow_d = 1'b1;
      end
      if_ready_d = (count_d < THR_CNT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         if_ready_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         if_ready_q <= if_ready_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= if_data;
      end
   end

   assign if_ready = if_ready_q;
   assign of_valid = (count_q != '0);
   assign of_data  = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_rs_hs_pipeline_tail.sv
// Directed bench for rs_hs_pipeline_tail: reset, streaming, threshold, overflow,
// pointer wrap and simultaneous push/pop at the threshold and full boundaries.
module tb_rs_hs_pipeline_tail;

   localparam int DW = 32;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_valid;
   logic [DW-1:0] if_data;
   logic          if_ready;
   logic          of_valid;
   logic [DW-1:0] of_data;
   logic          of_ready;
   logic [CW-1:0] count;
   logic          overflow;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   logic [DW-1:0] q[$];

   rs_hs_pipeline_tail #(
      .DATA_WIDTH(DW),
      .DEPTH(24),
      .GRACE_PERIOD(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .if_valid(if_valid),
      .if_data(if_data),
      .if_ready(if_ready),
      .of_valid(of_valid),
      .of_data(of_data),
      .of_ready(of_ready),
      .count(count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; expectations come from the queue model.
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
      bit do_push, do_pop;
      if_valid = v;
      if_data  = d;
      of_ready = r;
      do_push  = v && (q.size() != 33);
      do_pop   = r && (q.size() != 0);
      if (do_pop) check("of_data", of_data, q[0]);
      @(posedge clk); #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      check("count", DW'(count), DW'(q.size()));
   endtask

   initial begin
      int guard;
      reset = 1'b1; if_valid = 1'b1; if_data = 32'h55; of_ready = 1'b0;

      // Reset held with upstream still valid
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", DW'(count), 32'd0);
      check("rst_of_valid", DW'(of_valid), 32'd0);
      check("rst_if_ready", DW'(if_ready), 32'd0);
      check("rst_overflow", DW'(overflow), 32'd0);
      reset = 1'b0; if_valid = 1'b0;
      @(posedge clk); #1;
      check("if_ready_after_rst", DW'(if_ready), 32'd1);

      // Stream through with consumer always ready
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, DW'(i), 1'b1);
         check("stream_of_valid", DW'(of_valid), 32'd1);
         check("stream_head", of_data, DW'(i));
         check("stream_if_ready", DW'(if_ready), 32'd1);
      end
      cycle(1'b0, '0, 1'b1);
      check("stream_empty", DW'(of_valid), 32'd0);

      // Threshold fill, then the grace-period words
      for (int k = 1; k <= 33; k++) begin
         cycle(1'b1, 32'h1000 + DW'(k), 1'b0);
         check("fill_count", DW'(count), DW'(k));
         check("fill_if_ready", DW'(if_ready), (k < 28) ? 32'd1 : 32'd0);
         check("fill_overflow", DW'(overflow), 32'd0);
      end

      // Word at full is dropped and overflow sticks
      cycle(1'b1, 32'hDEAD, 1'b0);
      check("ovf_count", DW'(count), 32'd33);
      check("ovf_flag", DW'(overflow), 32'd1);
      for (int k = 1; k <= 33; k++) begin
         check("drain_val", of_data, 32'h1000 + DW'(k));
         cycle(1'b0, '0, 1'b1);
      end
      check("drain_of_valid", DW'(of_valid), 32'd0);
      check("ovf_sticky", DW'(overflow), 32'd1);

      // Asynchronous reset with contents present
      for (int k = 0; k < 4; k++) cycle(1'b1, 32'h3000 + DW'(k), 1'b0);
      reset = 1'b1; if_valid = 1'b1;
      #1;
      check("arst_count", DW'(count), 32'd0);
      check("arst_of_valid", DW'(of_valid), 32'd0);
      check("arst_if_ready", DW'(if_ready), 32'd0);
      check("arst_overflow", DW'(overflow), 32'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("arst_inflight", DW'(count), 32'd0);
      reset = 1'b0;

      // Simultaneous push/pop at 27 and at full
      for (int j = 0; j < 27; j++) cycle(1'b1, 32'h2000 + DW'(j), 1'b0);
      check("c27", DW'(count), 32'd27);
      check("c27_if_ready", DW'(if_ready), 32'd1);
      cycle(1'b1, 32'h2100, 1'b1);
      check("c27_pp_count", DW'(count), 32'd27);
      check("c27_pp_if_ready", DW'(if_ready), 32'd1);
      check("c27_pp_head", of_data, 32'h2001);
      for (int j = 1; j <= 6; j++) cycle(1'b1, 32'h2100 + DW'(j), 1'b0);
      check("c33", DW'(count), 32'd33);
      check("c33_overflow", DW'(overflow), 32'd0);
      cycle(1'b1, 32'hBEEF, 1'b1);
      check("c33_pp_count", DW'(count), 32'd32);
      check("c33_pp_overflow", DW'(overflow), 32'd1);
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
         cycle(1'b0, '0, 1'b1);
         guard++;
      end
      check("pp_drained", DW'(of_valid), 32'd0);

      // Fill/drain three times across pointer wrap, random consumer
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 33; k++) cycle(1'b1, $urandom, 1'b0);
         check("wrap_full", DW'(count), 32'd33);
         guard = 0;
         while (q.size() != 0 && guard < 1000) begin
            cycle(1'b0, '0, 1'($urandom_range(0, 1)));
            guard++;
         end
         check("wrap_empty", DW'(count), 32'd0);
         check("wrap_of_valid", DW'(of_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
